// File: rtl/cache_pkg.sv
// Shared types and address-field width helpers for the set-associative read cache.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS,
    S_REFILL,
    S_FLUSH
  } state_t;

  function automatic int off_bits(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int word_bits(input int line_w, input int data_w);
    return $clog2(line_w / data_w);
  endfunction

  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_w, input int line_w, input int sets);
    return addr_w - off_bits(line_w) - idx_bits(sets);
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: per-set valid bit, tag and line storage with combinational read.
module cache_way
  import cache_pkg::*;
#(
  parameter int SETS   = 64,
  parameter int TAG_W  = 22,
  parameter int LINE_W = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [idx_bits(SETS)-1:0] idx,
  input  logic                      wr_en,
  input  logic [TAG_W-1:0]          wr_tag,
  input  logic [LINE_W-1:0]         wr_line,
  output logic                      rd_valid,
  output logic [TAG_W-1:0]          rd_tag,
  output logic [LINE_W-1:0]         rd_line
);

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] line_q [SETS];

  // Only the valid bits need clearing; stale tag/data are masked by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid_q      <= '0;
    else if (clr)   valid_q      <= '0;
    else if (wr_en) valid_q[idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[idx]  <= wr_tag;
      line_q[idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = line_q[idx];

endmodule

// File: rtl/set_assoc_cache.sv
// Blocking set-associative read cache with line refill, invalidate-all and true-LRU replacement.
//   state    | meaning
//   S_IDLE   | ready for a request, or start a pending flush
//   S_LOOKUP | tag compare on the registered request
//   S_MISS   | rd_req held until memory returns the line
//   S_REFILL | deliver requested word from the freshly written line
//   S_FLUSH  | clear all valid bits and LRU state
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128,
  parameter int SETS   = 64,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              ready,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              ret_valid,
  input  logic [LINE_W-1:0] ret_data,
  input  logic              inv,
  output logic [31:0]       hit_cnt
);

  localparam int OFF_W  = off_bits(LINE_W);
  localparam int WSEL_W = word_bits(LINE_W, DATA_W);
  localparam int IDX_W  = idx_bits(SETS);
  localparam int TAG_W  = tag_bits(ADDR_W, LINE_W, SETS);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      req_q;
  logic                   flush_pend_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [31:0]            hit_cnt_q;
  logic [WAYS*WAYS-1:0]   lru_q [SETS];

  logic [IDX_W-1:0]       req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic [WSEL_W-1:0]      req_word;
  logic [WAYS-1:0]        way_valid, way_match, way_wr;
  logic [TAG_W-1:0]       way_tag  [WAYS];
  logic [LINE_W-1:0]      way_line [WAYS];
  logic                   hit, victim_found;
  logic [WAY_W-1:0]       hit_way, victim;
  logic [LINE_W-1:0]      hit_line;
  logic [DATA_W-1:0]      sel_word;
  logic [WAYS*WAYS-1:0]   cur_lru, new_lru;
  logic                   accept;

  assign req_idx  = req_q[OFF_W +: IDX_W];
  assign req_tag  = req_q[ADDR_W-1 -: TAG_W];
  assign req_word = req_q[OFF_W-1 -: WSEL_W];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way #(.SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_way (
      .clk      (clk),
      .rst      (rst),
      .clr      (state_q == S_FLUSH),
      .idx      (req_idx),
      .wr_en    (way_wr[g]),
      .wr_tag   (req_tag),
      .wr_line  (ret_data),
      .rd_valid (way_valid[g]),
      .rd_tag   (way_tag[g]),
      .rd_line  (way_line[g])
    );
    assign way_match[g] = way_valid[g] && (way_tag[g] == req_tag);
    assign way_wr[g]    = (state_q == S_MISS) && ret_valid && (victim == WAY_W'(g));
  end

  // LRU matrix: bit [i*WAYS+j] set means way i was used more recently than way j.
  assign cur_lru = lru_q[req_idx];

  always_comb begin
    hit          = 1'b0;
    hit_way      = '0;
    victim       = '0;
    victim_found = 1'b0;
    new_lru      = cur_lru;
    for (int w = 0; w < WAYS; w++) begin
      if (way_match[w] && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!way_valid[w] && !victim_found) begin
        victim       = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
    // A way whose row is all zero is more recent than nobody: the LRU way.
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && (cur_lru[w*WAYS +: WAYS] == '0)) begin
        victim       = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
    for (int j = 0; j < WAYS; j++) begin
      if (j != int'(hit_way)) begin
        new_lru[int'(hit_way)*WAYS + j] = 1'b1;
        new_lru[j*WAYS + int'(hit_way)] = 1'b0;
      end
    end
  end

  assign hit_line = way_line[hit_way];
  assign sel_word = hit_line[int'(req_word)*DATA_W +: DATA_W];

  assign ready   = (state_q == S_IDLE) && !flush_pend_q && !inv;
  assign accept  = valid && ready;
  assign data_ok = ((state_q == S_LOOKUP) || (state_q == S_REFILL)) && hit;
  assign rdata   = data_ok ? sel_word : rdata_q;
  assign rd_req  = (state_q == S_MISS);
  assign rd_addr = rd_req ? {req_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign hit_cnt = hit_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (inv || flush_pend_q) state_d = S_FLUSH;
                else if (valid)          state_d = S_LOOKUP;
      S_LOOKUP: state_d = hit ? S_IDLE : S_MISS;
      S_MISS:   if (ret_valid) state_d = S_REFILL;
      S_REFILL: state_d = S_IDLE;
      S_FLUSH:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_q        <= '0;
      flush_pend_q <= 1'b0;
      rdata_q      <= '0;
      hit_cnt_q    <= '0;
      for (int s = 0; s < SETS; s++) lru_q[s] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) req_q <= addr_i;
      // IDLE either starts the flush itself or has nothing pending.
      if (state_q == S_IDLE) flush_pend_q <= 1'b0;
      else if (inv)          flush_pend_q <= 1'b1;
      if (data_ok) rdata_q <= sel_word;
      if ((state_q == S_LOOKUP) && hit && (hit_cnt_q != 32'hFFFF_FFFF))
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == S_FLUSH) begin
        for (int s = 0; s < SETS; s++) lru_q[s] <= '0;
      end else if (data_ok) begin
        lru_q[req_idx] <= new_lru;
      end
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: vector table of reads plus flush/reset corner sequences.
module tb_set_assoc_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [31:0]  addr_i;
  logic         ready;
  logic         data_ok;
  logic [31:0]  rdata;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         ret_valid;
  logic [127:0] ret_data;
  logic         inv;
  logic [31:0]  hit_cnt;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] exp_hits;

  set_assoc_cache dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .addr_i    (addr_i),
    .ready     (ready),
    .data_ok   (data_ok),
    .rdata     (rdata),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .ret_valid (ret_valid),
    .ret_data  (ret_data),
    .inv       (inv),
    .hit_cnt   (hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          miss;
    logic [31:0] exp;
    int          dly;
  } vec_t;

  vec_t vecs [15];

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  // Memory model: the DEBA_D000 line is fixed; other words are (word address ^ 5A5A0000).
  function automatic logic [127:0] line_for(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = a & ~32'hF;
    if (base == 32'hDEBA_D000) return 128'h34567891_02345678_91023456_78910234;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = (base + 32'(4*k)) ^ 32'h5A5A_0000;
    return l;
  endfunction

  task automatic do_read(input logic [31:0] a, input bit miss, input logic [31:0] exp,
                         input int dly, input bit inv_mid);
    int w;
    w = 0;
    while (!ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk1("ready_before_req", ready, 1'b1);
    valid  = 1'b1;
    addr_i = a;
    @(negedge clk);
    valid  = 1'b0;
    addr_i = '0;
    chk1("data_ok_in_lookup", data_ok, !miss);
    if (!miss) begin
      exp_hits = exp_hits + 32'd1;
      chk32("hit_rdata", rdata, exp);
    end else begin
      @(negedge clk);
      chk1("rd_req", rd_req, 1'b1);
      chk32("rd_addr", rd_addr, a & ~32'hF);
      for (int d = 0; d < dly; d++) begin
        @(negedge clk);
        chk1("rd_req_hold", rd_req, 1'b1);
        chk1("no_data_ok_in_miss", data_ok, 1'b0);
      end
      if (inv_mid) begin
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        chk1("rd_req_after_inv", rd_req, 1'b1);
      end
      ret_valid = 1'b1;
      ret_data  = line_for(a);
      @(negedge clk);
      ret_valid = 1'b0;
      ret_data  = '0;
      chk1("refill_data_ok", data_ok, 1'b1);
      chk32("refill_rdata", rdata, exp);
      chk1("rd_req_dropped", rd_req, 1'b0);
    end
    @(negedge clk);
    chk1("data_ok_one_cycle", data_ok, 1'b0);
    chk32("rdata_hold", rdata, exp);
    chk32("hit_cnt", hit_cnt, exp_hits);
    chk1("ready_after_read", ready, !inv_mid);
  endtask

  initial begin
    vecs[0]  = '{32'hDEBA_D000, 1'b1, 32'h7891_0234, 1};
    vecs[1]  = '{32'hDEBA_D004, 1'b0, 32'h9102_3456, 0};
    vecs[2]  = '{32'hDEBA_D00C, 1'b0, 32'h3456_7891, 0};
    vecs[3]  = '{32'h0000_1000, 1'b1, 32'h5A5A_1000, 0};
    vecs[4]  = '{32'h0000_2008, 1'b1, 32'h5A5A_2008, 2};
    vecs[5]  = '{32'h0000_1004, 1'b0, 32'h5A5A_1004, 0};
    vecs[6]  = '{32'h0000_3000, 1'b1, 32'h5A5A_3000, 0};
    vecs[7]  = '{32'h0000_100C, 1'b0, 32'h5A5A_100C, 0};
    vecs[8]  = '{32'h0000_3004, 1'b0, 32'h5A5A_3004, 0};
    vecs[9]  = '{32'h0000_2000, 1'b1, 32'h5A5A_2000, 0};
    vecs[10] = '{32'h0000_3008, 1'b0, 32'h5A5A_3008, 0};
    vecs[11] = '{32'h0000_1000, 1'b1, 32'h5A5A_1000, 0};
    vecs[12] = '{32'hDEBA_D008, 1'b1, 32'h0234_5678, 0};
    vecs[13] = '{32'h0000_1010, 1'b1, 32'h5A5A_1010, 0};
    vecs[14] = '{32'h0000_1018, 1'b0, 32'h5A5A_1018, 0};

    rst = 1'b1; valid = 1'b0; addr_i = '0; ret_valid = 1'b0; ret_data = '0; inv = 1'b0;
    exp_hits = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("reset_ready", ready, 1'b1);
    chk1("reset_data_ok", data_ok, 1'b0);
    chk1("reset_rd_req", rd_req, 1'b0);
    chk32("reset_rd_addr", rd_addr, 32'h0);
    chk32("reset_rdata", rdata, 32'h0);
    chk32("reset_hit_cnt", hit_cnt, 32'h0);

    for (int i = 0; i < 15; i++)
      do_read(vecs[i].addr, vecs[i].miss, vecs[i].exp, vecs[i].dly, 1'b0);

    // Invalidate during a miss: miss finishes, flush follows, line is gone.
    do_read(32'h0000_4000, 1'b1, 32'h5A5A_4000, 0, 1'b1);
    chk1("flush_ready_low", ready, 1'b0);
    @(negedge clk);
    do_read(32'h0000_4000, 1'b1, 32'h5A5A_4000, 0, 1'b0);

    // inv and valid together: flush wins, the held request goes in afterwards.
    inv    = 1'b1;
    valid  = 1'b1;
    addr_i = 32'h0000_1018;
    #1 chk1("inv_valid_ready_low", ready, 1'b0);
    @(negedge clk);
    inv = 1'b0;
    chk1("inv_valid_not_accepted", data_ok, 1'b0);
    chk1("inv_valid_no_rd_req", rd_req, 1'b0);
    chk1("inv_valid_flush_ready", ready, 1'b0);
    @(negedge clk);
    chk1("held_req_ready", ready, 1'b1);
    do_read(32'h0000_1018, 1'b1, 32'h5A5A_1018, 0, 1'b0);

    // Reset in MISS: refill abandoned, late ret_valid ignored.
    valid  = 1'b1;
    addr_i = 32'h0000_5000;
    @(negedge clk);
    valid  = 1'b0;
    @(negedge clk);
    chk1("pre_reset_rd_req", rd_req, 1'b1);
    rst = 1'b1;
    #1 chk1("reset_in_miss_rd_req", rd_req, 1'b0);
    @(negedge clk);
    rst       = 1'b0;
    exp_hits  = '0;
    ret_valid = 1'b1;
    ret_data  = line_for(32'h0000_5000);
    @(negedge clk);
    ret_valid = 1'b0;
    ret_data  = '0;
    chk1("late_ret_no_data_ok", data_ok, 1'b0);
    @(negedge clk);
    chk1("late_ret_no_data_ok2", data_ok, 1'b0);
    chk1("late_ret_rd_req", rd_req, 1'b0);
    chk32("post_reset_hit_cnt", hit_cnt, 32'h0);
    chk32("post_reset_rdata", rdata, 32'h0);
    do_read(32'h0000_5000, 1'b1, 32'h5A5A_5000, 0, 1'b0);

    // Stray ret_valid in IDLE must not disturb the stored line.
    ret_valid = 1'b1;
    ret_data  = '1;
    @(negedge clk);
    ret_valid = 1'b0;
    ret_data  = '0;
    do_read(32'h0000_5004, 1'b0, 32'h5A5A_5004, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
